// File: rtl/audio_ram_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : audio_ram_sequencer
// Description : Sequences byte-wide RAM traffic for an audio path.
//               Playback mode prefetches RAM bytes into a small FIFO that the
//               codec drains with sample_req. Record mode writes each
//               captured byte to RAM through a one-byte pending register.
//               The address runs 0..end_addr and then wraps to 0.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   play_en       in   playback mode request (level, wins over rec_en)
//   rec_en        in   record mode request (level)
//   end_addr      in   last valid RAM address (wrap point)
//   ram_rdy       in   RAM ready; gates the start of new transactions
//   rd_data_pres  in   RAM read data valid, held until read_ack
//   ram_data_out  in   RAM read data
//   read_request  out  RAM read request (level)
//   read_ack      out  one-cycle pulse consuming RAM read data
//   write_enable  out  one-cycle RAM write strobe
//   address       out  current RAM address
//   ram_data_in   out  RAM write data
//   sample_req    in   codec takes the next playback sample
//   sample_out    out  head of the prefetch FIFO
//   rec_valid     in   rec_sample valid pulse
//   rec_sample    in   captured audio byte
//   underrun      out  sticky: sample_req seen with FIFO empty
//   overrun       out  sticky: record byte overwritten before written
//   wrapped       out  one-cycle pulse on the end_addr -> 0 address step
// ============================================================================
module audio_ram_sequencer #(
    parameter int ADDR_W     = 26,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_en,
    input  logic              rec_en,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              ram_rdy,
    input  logic              rd_data_pres,
    input  logic [7:0]        ram_data_out,
    output logic              read_request,
    output logic              read_ack,
    output logic              write_enable,
    output logic [ADDR_W-1:0] address,
    output logic [7:0]        ram_data_in,
    input  logic              sample_req,
    output logic [7:0]        sample_out,
    input  logic              rec_valid,
    input  logic [7:0]        rec_sample,
    output logic              underrun,
    output logic              overrun,
    output logic              wrapped
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_RD_REQ     = 3'd1;
    localparam logic [2:0] c_RD_ACK     = 3'd2;
    localparam logic [2:0] c_RD_RELEASE = 3'd3;
    localparam logic [2:0] c_WR         = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [ADDR_W-1:0]  r_address;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_pend_valid;
    logic [7:0]         r_pend_data;
    logic               r_underrun;
    logic               r_overrun;
    logic               r_mode_rec;
    logic               r_discard;

    logic w_advance;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_play;
    logic w_rec;
    logic w_mode_switch;

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);
    assign w_play  = play_en;
    assign w_rec   = !play_en && rec_en;

    // Address restarts at 0 only when the active mode actually flips
    // between play and record; dropping both requests keeps the position.
    assign w_mode_switch = (r_state == c_IDLE) &&
                           ((w_play && r_mode_rec) || (w_rec && !r_mode_rec));

    // Read data is dropped if playback was abandoned during the read.
    assign w_push = (r_state == c_RD_ACK) && play_en && !r_discard && !w_full;
    assign w_pop  = sample_req && !w_empty;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (ram_rdy && play_en && !w_full) begin
                    w_next_state = c_RD_REQ;
                end else if (ram_rdy && w_rec && r_pend_valid) begin
                    w_next_state = c_WR;
                end
            end
            c_RD_REQ: begin
                if (rd_data_pres) begin
                    w_next_state = c_RD_ACK;
                end
            end
            c_RD_ACK:     w_next_state = c_RD_RELEASE;
            c_RD_RELEASE: begin
                if (!rd_data_pres) begin
                    w_next_state = c_IDLE;
                end
            end
            c_WR:         w_next_state = c_IDLE;
            default:      w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        read_request = 1'b0;
        read_ack     = 1'b0;
        write_enable = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            c_RD_REQ: read_request = 1'b1;
            c_RD_ACK: begin
                read_ack  = 1'b1;
                w_advance = 1'b1;
            end
            c_WR: begin
                write_enable = 1'b1;
                w_advance    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------ address
    always_ff @(posedge clk) begin
        if (reset) begin
            r_address  <= '0;
            r_mode_rec <= 1'b0;
        end else begin
            if (w_mode_switch) begin
                r_address <= '0;
            end else if (w_advance) begin
                r_address <= (r_address == end_addr) ? '0 : r_address + ADDR_W'(1);
            end
            if (r_state == c_IDLE) begin
                if (w_play) begin
                    r_mode_rec <= 1'b0;
                end else if (w_rec) begin
                    r_mode_rec <= 1'b1;
                end
            end
        end
    end

    // Marks an in-flight read whose data must not reach the FIFO.
    always_ff @(posedge clk) begin
        if (reset || r_state == c_IDLE) begin
            r_discard <= 1'b0;
        end else if (!play_en && r_state != c_WR) begin
            r_discard <= 1'b1;
        end
    end

    // --------------------------------------------------------- prefetch FIFO
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ram_data_out;
        end
    end

    // Leaving playback flushes the FIFO on the next edge.
    always_ff @(posedge clk) begin
        if (reset || !play_en) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_underrun <= 1'b0;
        end else if (sample_req && w_empty) begin
            r_underrun <= 1'b1;
        end
    end

    // ------------------------------------------------------ record pending
    // A byte arriving during WR replaces the one being written this cycle,
    // so it is not counted as an overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_data  <= 8'h00;
            r_overrun    <= 1'b0;
        end else if (!rec_en) begin
            r_pend_valid <= 1'b0;
        end else if (rec_valid) begin
            r_pend_valid <= 1'b1;
            r_pend_data  <= rec_sample;
            if (r_pend_valid && r_state != c_WR) begin
                r_overrun <= 1'b1;
            end
        end else if (r_state == c_WR) begin
            r_pend_valid <= 1'b0;
        end
    end

    // -------------------------------------------------------------- outputs
    assign address     = r_address;
    assign ram_data_in = r_pend_data;
    assign sample_out  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign underrun    = r_underrun;
    assign overrun     = r_overrun;
    assign wrapped     = w_advance && (r_address == end_addr);

endmodule
`default_nettype wire

// File: tb/tb_audio_ram_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_ram_sequencer
// Description : Scoreboard bench for audio_ram_sequencer. A RAM model serves
//               reads with 2-cycle latency; expected samples and writes are
//               queued from the address/wrap rules and checked by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_ram_sequencer;

    logic        clk;
    logic        reset;
    logic        play_en;
    logic        rec_en;
    logic [25:0] end_addr;
    logic        ram_rdy;
    logic        rd_data_pres;
    logic [7:0]  ram_data_out;
    logic        read_request;
    logic        read_ack;
    logic        write_enable;
    logic [25:0] address;
    logic [7:0]  ram_data_in;
    logic        sample_req;
    logic [7:0]  sample_out;
    logic        rec_valid;
    logic [7:0]  rec_sample;
    logic        underrun;
    logic        overrun;
    logic        wrapped;

    audio_ram_sequencer #(.ADDR_W(26), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .play_en(play_en), .rec_en(rec_en),
        .end_addr(end_addr), .ram_rdy(ram_rdy), .rd_data_pres(rd_data_pres),
        .ram_data_out(ram_data_out), .read_request(read_request),
        .read_ack(read_ack), .write_enable(write_enable), .address(address),
        .ram_data_in(ram_data_in), .sample_req(sample_req),
        .sample_out(sample_out), .rec_valid(rec_valid),
        .rec_sample(rec_sample), .underrun(underrun), .overrun(overrun),
        .wrapped(wrapped)
    );

    initial clk = 1'b0;
    initial forever #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ram [16];
    logic [7:0] exp_samples [$];
    int         exp_wa [$];
    logic [7:0] exp_wd [$];

    int n_acked    = 0;   // monitor-owned
    int n_popped   = 0;   // monitor-owned
    int n_served   = 0;   // RAM-model-owned
    int base       = 0;   // stimulus-owned session offsets
    int ack_base   = 0;
    int serve_base = 0;
    int wr_k       = 0;
    bit chk_samples = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    function automatic int avail();
        return n_acked - n_popped - base;
    endfunction

    // RAM model: data ready two cycles after the request, held until read_ack.
    initial begin
        int lat;
        lat = 0;
        rd_data_pres = 1'b0;
        ram_data_out = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                rd_data_pres = 1'b0;
                lat = 0;
            end else if (rd_data_pres) begin
                if (read_ack) rd_data_pres = 1'b0;
            end else if (read_request) begin
                lat++;
                if (lat >= 2) begin
                    ram_data_out = ram[address[3:0]];
                    rd_data_pres = 1'b1;
                    lat = 0;
                    exp_samples.push_back(ram[(n_served - serve_base) % (int'(end_addr) + 1)]);
                    n_served++;
                end
            end else begin
                lat = 0;
            end
        end
    end

    // Monitor: samples mid-cycle, pops scoreboard queues on DUT events.
    initial begin
        int k;
        bit prev_rr;
        prev_rr = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (!reset) begin
                if (read_request || write_enable)
                    chk("rd_wr_exclusive", 32'(read_request & write_enable), 0);
                if (read_request && !prev_rr)
                    chk("read_while_full", 32'(avail() >= 4), 0);
                if (wrapped)
                    chk("wrapped_only_on_step", 32'(read_ack | write_enable), 1);
                if (read_ack) begin
                    k = (n_acked - ack_base) % (int'(end_addr) + 1);
                    chk("rd_addr", address, k);
                    chk("rd_wrapped", wrapped, 32'(k == int'(end_addr)));
                    n_acked++;
                end
                if (write_enable) begin
                    if (exp_wa.size() == 0) begin
                        fail_now("unexpected_write");
                    end else begin
                        k = exp_wa.pop_front();
                        chk("wr_addr", address, k);
                        chk("wr_data", ram_data_in, exp_wd.pop_front());
                        chk("wr_wrapped", wrapped, 32'(k == int'(end_addr)));
                    end
                end
                if (sample_req && chk_samples) begin
                    if (exp_samples.size() == 0) fail_now("unexpected_sample");
                    else chk("sample", sample_out, exp_samples.pop_front());
                    n_popped++;
                end
            end
            prev_rr = read_request;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; play_en = 1'b0; rec_en = 1'b0; ram_rdy = 1'b0;
        sample_req = 1'b0; rec_valid = 1'b0; chk_samples = 1'b0;
        tick(2);
        base = n_acked - n_popped;
        ack_base = n_acked;
        serve_base = n_served;
        exp_samples.delete();
        exp_wa.delete();
        exp_wd.delete();
        wr_k = 0;
        reset = 1'b0;
    endtask

    task automatic play_random(input int n);
        int pops;
        pops = 0;
        for (int cyc = 0; cyc < 4000 && pops < n; cyc++) begin
            @(negedge clk);
            ram_rdy = ($urandom_range(0, 4) != 0);
            if (avail() > 0 && $urandom_range(0, 2) == 0) begin
                sample_req = 1'b1;
                pops++;
            end else begin
                sample_req = 1'b0;
            end
        end
        @(negedge clk);
        sample_req = 1'b0;
        ram_rdy = 1'b1;
        chk("play_pops_done", pops, n);
    endtask

    task automatic send_rec(input logic [7:0] b, input bit expect_write);
        if (expect_write) begin
            exp_wa.push_back(wr_k % (int'(end_addr) + 1));
            exp_wd.push_back(b);
            wr_k++;
        end
        rec_sample = b;
        rec_valid = 1'b1;
        @(negedge clk);
        rec_valid = 1'b0;
    endtask

    task automatic wait_writes(input string name);
        for (int i = 0; i < 60 && exp_wa.size() != 0; i++) @(negedge clk);
        chk(name, exp_wa.size(), 0);
    endtask

    initial begin
        int acks0;
        reset = 1'b1; play_en = 1'b0; rec_en = 1'b0; ram_rdy = 1'b0;
        sample_req = 1'b0; rec_valid = 1'b0; rec_sample = 8'h00;
        end_addr = 26'd9;
        for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
        ram[0] = 8'hA0; ram[1] = 8'hA1; ram[2] = 8'hA2; ram[3] = 8'hA3;

        // Reset state
        do_reset();
        chk("rst_read_request", read_request, 0);
        chk("rst_read_ack", read_ack, 0);
        chk("rst_write_enable", write_enable, 0);
        chk("rst_wrapped", wrapped, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_address", address, 0);
        chk("rst_ram_data_in", ram_data_in, 0);
        chk("rst_sample_out", sample_out, 0);

        // Prefetch fills the FIFO, then idles until a sample is taken
        chk_samples = 1'b1; play_en = 1'b1; ram_rdy = 1'b1;
        for (int i = 0; i < 200 && avail() != 4; i++) @(negedge clk);
        chk("prefetch_count", avail(), 4);
        chk("prefetch_address", address, 4);
        acks0 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (read_request) acks0++;
        end
        chk("prefetch_full_no_read", acks0, 0);
        chk("prefetch_head", sample_out, 32'hA0);
        play_random(30);

        // Flush on play_en fall, observed through an underrun on the next take
        for (int i = 0; i < 100 && avail() == 0; i++) @(negedge clk);
        chk("play_no_underrun", underrun, 0);
        chk_samples = 1'b0;
        play_en = 1'b0;
        tick(8);
        sample_req = 1'b1;
        tick(1);
        sample_req = 1'b0;
        tick(1);
        chk("flush_empties_fifo", underrun, 1);

        // Wrap with end_addr = 3
        do_reset();
        end_addr = 26'd3;
        chk_samples = 1'b1; play_en = 1'b1; ram_rdy = 1'b1;
        play_random(20);

        // Record
        do_reset();
        end_addr = 26'd4;
        rec_en = 1'b1; ram_rdy = 1'b1;
        send_rec(8'h5C, 1'b1);
        wait_writes("rec_first_write");
        tick(1);
        chk("rec_address_after", address, 1);
        for (int n = 0; n < 12; n++) begin
            send_rec(8'($urandom), 1'b1);
            wait_writes("rec_random_write");
            tick($urandom_range(0, 2));
        end
        ram_rdy = 1'b0;
        send_rec(8'hEE, 1'b0);
        tick(2);
        rec_en = 1'b0;
        tick(1);
        rec_en = 1'b1; ram_rdy = 1'b1;
        tick(6);
        chk("rec_en_fall_no_write", address, wr_k % 5);
        chk("rec_no_overrun", overrun, 0);

        // Overrun: second byte replaces the first, single write
        do_reset();
        end_addr = 26'd9;
        rec_en = 1'b1; ram_rdy = 1'b0;
        send_rec(8'h11, 1'b0);
        send_rec(8'h22, 1'b1);
        tick(1);
        chk("overrun_set", overrun, 1);
        ram_rdy = 1'b1;
        wait_writes("overrun_write");
        tick(3);
        chk("overrun_sticky", overrun, 1);

        // Underrun with RAM not ready
        do_reset();
        play_en = 1'b1; ram_rdy = 1'b0;
        acks0 = n_acked;
        tick(2);
        sample_req = 1'b1;
        tick(1);
        sample_req = 1'b0;
        tick(2);
        chk("underrun_set", underrun, 1);
        chk("underrun_no_read", read_request, 0);
        chk("underrun_no_fill", n_acked - acks0, 0);
        tick(3);
        chk("underrun_sticky", underrun, 1);

        // Reset while in RD_REQ
        do_reset();
        end_addr = 26'd9;
        play_en = 1'b1; ram_rdy = 1'b1;
        for (int i = 0; i < 20 && !read_request; i++) @(negedge clk);
        chk("midread_req_seen", read_request, 1);
        acks0 = n_acked;
        reset = 1'b1;
        @(negedge clk);
        chk("midread_req_dropped", read_request, 0);
        chk("midread_address", address, 0);
        chk("midread_no_ack_now", read_ack, 0);
        play_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick(6);
        chk("midread_no_ack_later", n_acked - acks0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/audio_ram_sequencer.md
AUDIO_RAM_SEQUENCER -- requirements
Module: audio_ram_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 26, RAM byte-address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, playback prefetch FIFO entries (power of 2, 2..16).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port play_en  input  1  playback mode request, level.
REQ-006 SHALL have port rec_en  input  1  record mode request, level; play_en wins if both are high.
REQ-007 SHALL have port end_addr  input  ADDR_W  last valid address; wrap point.
REQ-008 SHALL have port ram_rdy  input  1  RAM calibrated/ready.
REQ-009 SHALL have port rd_data_pres  input  1  RAM read data valid, held until read_ack.
REQ-010 SHALL have port ram_data_out  input  8  RAM read data.
REQ-011 SHALL have port read_request  output  1  RAM read request, level.
REQ-012 SHALL have port read_ack  output  1  one-cycle pulse consuming RAM read data.
REQ-013 SHALL have port write_enable  output  1  one-cycle RAM write strobe.
REQ-014 SHALL have port address  output  ADDR_W  current RAM address.
REQ-015 SHALL have port ram_data_in  output  8  RAM write data.
REQ-016 SHALL have port sample_req  input  1  one-cycle pulse from audio codec taking the next playback sample.
REQ-017 SHALL have port sample_out  output  8  head of prefetch FIFO, valid while fifo_count>0.
REQ-018 SHALL have port rec_valid  input  1  one-cycle pulse, rec_sample valid.
REQ-019 SHALL have port rec_sample  input  8  captured audio byte.
REQ-020 SHALL have port underrun  output  1  sticky: sample_req seen with FIFO empty.
REQ-021 SHALL have port overrun  output  1  sticky: rec_valid seen while a write was pending.
REQ-022 SHALL have port wrapped  output  1  one-cycle pulse when address wraps end_addr->0.

Function
REQ-023 FSM states SHALL be IDLE, RD_REQ, RD_ACK, RD_RELEASE, WR.
REQ-024 IDLE->RD_REQ SHALL occur when ram_rdy & play_en & FIFO not full.
REQ-025 RD_REQ SHALL hold read_request=1 until rd_data_pres=1, then go RD_ACK.
REQ-026 In RD_ACK, read_request SHALL be 0, ram_data_out SHALL be pushed into the FIFO, read_ack SHALL be 1 for exactly that cycle, and address SHALL advance; next state RD_RELEASE.
REQ-027 RD_RELEASE SHALL wait for rd_data_pres=0, then return to IDLE.
REQ-028 In IDLE with play_en=0 & rec_en=1 & ram_rdy & a pending record byte, the FSM SHALL go WR.
REQ-029 WR SHALL drive write_enable=1 with ram_data_in=pending byte for one cycle, advance address, clear pending, and return to IDLE.
REQ-030 A rec_valid pulse SHALL latch rec_sample into a one-byte pending register; if pending is already set, the new byte SHALL overwrite it and overrun SHALL be set.
REQ-031 Address advance SHALL be address+1, except address==end_addr SHALL give 0 with wrapped=1 for that cycle.
REQ-032 A sample_req with fifo_count>0 SHALL pop one entry; sample_out SHALL show the next entry the following cycle.
REQ-033 A sample_req with the FIFO empty SHALL pop nothing and SHALL set underrun.
REQ-034 A push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-035 The FIFO SHALL never push when full; the FSM SHALL not leave IDLE for a read while full.
REQ-036 A fall of play_en SHALL flush the FIFO next cycle; an in-flight read SHALL still complete RD_ACK/RD_RELEASE, and its data SHALL be discarded.
REQ-037 A fall of rec_en SHALL clear the pending byte without a write.
REQ-038 Switching between play and record modes SHALL reset address to 0 when the FSM is in IDLE.
REQ-039 read_request and write_enable SHALL never be high in the same cycle.
REQ-040 ram_rdy=0 SHALL block new transactions only; transactions already started SHALL complete.

Reset
REQ-041 reset=1 at a clock edge SHALL force state IDLE; address, fifo_count, and the pending byte SHALL be 0; read_request, read_ack, write_enable, wrapped, underrun, and overrun SHALL be 0; ram_data_in and sample_out SHALL be 8'h00.
REQ-042 Reset in mid-transaction SHALL drop read_request the next cycle with no read_ack issued.
REQ-043 Sticky flags SHALL clear only on reset.

Verification
REQ-044 Prefetch: play_en=1, ram_rdy=1, RAM model returns 8'hA0,A1,A2,A3 at 2-cycle latency -> 4 reads, address 0->4, FIFO full, read_request stays 0 until sample_req, then sample_out=8'hA0.
REQ-045 Wrap: end_addr=3, play_en=1, continuous sample_req -> address sequence 0,1,2,3,0 with wrapped pulsed once at the 3->0 step.
REQ-046 Record: play_en=0, rec_en=1, rec_valid with 8'h5C -> exactly one write_enable pulse with ram_data_in=8'h5C and address 0, then address=1.
REQ-047 Overrun: two rec_valid pulses (8'h11, 8'h22) back-to-back while ram_rdy=0 -> overrun=1, and after ram_rdy=1 the single write carries 8'h22.
REQ-048 Underrun: play_en=1, ram_rdy=0, sample_req pulse -> underrun=1 and fifo_count stays 0.
REQ-049 Reset mid-read: reset asserted in RD_REQ -> read_request=0 the next cycle, address=0, and no read_ack.
